imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 14 +
 rtl/imm_extract.sv | 71 +++++++
 rtl/imm_gen_pipe.sv | 123 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate generator.
//   IMM_* : 3-bit immediate format select codes driven on in_sel.
package imm_pkg;

    localparam logic [2:0] IMM_ZERO  = 3'b000;
    localparam logic [2:0] IMM_J     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_I     = 3'b011;
    localparam logic [2:0] IMM_S     = 3'b100;
    localparam logic [2:0] IMM_U     = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_SHAMT = 3'b111;

endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational RISC-V immediate extraction.
//   inst : raw 32-bit instruction word
//   sel  : format select (imm_pkg::IMM_*)
//   imm  : immediate, XLEN wide (sign- or zero-extended per format)
//   err  : zimm select used on a register-form CSR (inst[14] clear)
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    localparam bit Is64 = (XLEN == 64);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extract: XLEN must be 32 or 64, got %0d", XLEN);
    end

    // Every format is first assembled as a 32-bit value; sext marks formats whose
    // bit 31 must be replicated into the upper half when XLEN=64.
    logic [31:0] base;
    logic        sext;

    always_comb begin
        base = '0;
        sext = 1'b0;
        case (sel)
            IMM_I: begin
                base = {{20{inst[31]}}, inst[31:20]};
                sext = 1'b1;
            end
            IMM_S: begin
                base = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                sext = 1'b1;
            end
            IMM_B: begin
                base = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                sext = 1'b1;
            end
            IMM_J: begin
                base = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                sext = 1'b1;
            end
            IMM_U: begin
                base = {inst[31:12], 12'b0};
                sext = 1'b1;
            end
            IMM_ZIMM:  base = {27'b0, inst[19:15]};
            IMM_SHAMT: base = Is64 ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
            default:   base = '0;
        endcase
    end

    always_comb begin
        imm = XLEN'(base);
        if (sext) begin
            imm = XLEN'($signed(base));
        end
    end

    assign err = (sel == IMM_ZIMM) && !inst[14];

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: valid/ready wrapper around imm_extract with a 2-entry
// output + skid buffer. Results leave in acceptance order.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : input handshake (in_ready registered)
//   in_inst/in_sel/in_tag : instruction, format select, sideband tag
//   out_valid/out_ready   : output handshake
//   out_imm/out_tag/out_err : result, held stable while stalled
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    logic [XLEN-1:0] new_imm;
    logic            new_err;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .inst(in_inst),
        .sel (in_sel),
        .imm (new_imm),
        .err (new_err)
    );

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_err_q, out_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;

    logic accept;
    logic drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;

        if (!out_valid_q || drain) begin
            // Output slot frees up: oldest entry (skid) first, else the new beat.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = new_imm;
                out_tag_d   = in_tag;
                out_err_d   = new_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Stalled output: park the new beat. accept implies the skid is empty.
            skid_valid_d = 1'b1;
            skid_imm_d   = new_imm;
            skid_tag_d   = in_tag;
            skid_err_d   = new_err;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench driving an XLEN=32 and an XLEN=64 instance
// with identical stimulus; table of format vectors plus stall/reset sequences.
module tb_imm_gen_pipe;

    localparam int unsigned TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [31:0] in_inst;
    logic [2:0] in_sel;
    logic [TAG_W-1:0] in_tag;

    logic rdy32, v32, e32;
    logic [31:0] imm32;
    logic [TAG_W-1:0] tag32;
    logic rdy64, v64, e64;
    logic [63:0] imm64;
    logic [TAG_W-1:0] tag64;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (rdy32),
        .in_inst  (in_inst),
        .in_sel   (in_sel),
        .in_tag   (in_tag),
        .out_valid(v32),
        .out_ready(out_ready),
        .out_imm  (imm32),
        .out_tag  (tag32),
        .out_err  (e32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (rdy64),
        .in_inst  (in_inst),
        .in_sel   (in_sel),
        .in_tag   (in_tag),
        .out_valid(v64),
        .out_ready(out_ready),
        .out_imm  (imm64),
        .out_tag  (tag64),
        .out_err  (e64)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [4:0]  tag;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full result check on both instances; only meaningful when out_valid is expected high.
    task automatic check_out(input string name, input logic [31:0] x32, input logic [63:0] x64,
                             input logic [4:0] tag, input logic err);
        check({name, " v32"}, 64'(v32), 64'd1);
        check({name, " v64"}, 64'(v64), 64'd1);
        check({name, " imm32"}, 64'(imm32), 64'(x32));
        check({name, " imm64"}, imm64, x64);
        check({name, " tag32"}, 64'(tag32), 64'(tag));
        check({name, " tag64"}, 64'(tag64), 64'(tag));
        check({name, " err32"}, 64'(e32), 64'(err));
        check({name, " err64"}, 64'(e64), 64'(err));
    endtask

    task automatic check_hs(input string name, input logic valid, input logic rdy);
        check({name, " v32"}, 64'(v32), 64'(valid));
        check({name, " v64"}, 64'(v64), 64'(valid));
        check({name, " rdy32"}, 64'(rdy32), 64'(rdy));
        check({name, " rdy64"}, 64'(rdy64), 64'(rdy));
    endtask

    // I-type word whose immediate equals v.
    function automatic logic [31:0] i_inst(input int v);
        return (32'(v) << 20) | 32'h13;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [2:0] sel, input logic [4:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 3'b011, 5'd1,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h7FF00013, 3'b011, 5'd2,  32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[2]  = '{32'h80000037, 3'b101, 5'd3,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[3]  = '{32'h12345037, 3'b101, 5'd4,  32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[4]  = '{32'h8000006F, 3'b001, 5'd5,  32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[5]  = '{32'h7FFFF06F, 3'b001, 5'd6,  32'h000FFFFE, 64'h00000000000FFFFE, 1'b0};
        vecs[6]  = '{32'h80000063, 3'b010, 5'd7,  32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
        vecs[7]  = '{32'h00000FE3, 3'b010, 5'd8,  32'h0000081E, 64'h000000000000081E, 1'b0};
        vecs[8]  = '{32'h120001A3, 3'b100, 5'd9,  32'h00000123, 64'h0000000000000123, 1'b0};
        vecs[9]  = '{32'h03F00013, 3'b111, 5'd10, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[10] = '{32'h02000013, 3'b111, 5'd11, 32'h00000000, 64'h0000000000000020, 1'b0};
        // 0x0002D073 has inst[14]=1 (immediate-form CSR): no error.
        vecs[11] = '{32'h0002D073, 3'b110, 5'd12, 32'h00000005, 64'h0000000000000005, 1'b0};
        vecs[12] = '{32'h00029073, 3'b110, 5'd13, 32'h00000005, 64'h0000000000000005, 1'b1};
        vecs[13] = '{32'hFFFFFFFF, 3'b000, 5'd14, 32'h00000000, 64'h0000000000000000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_inst   = '0;
        in_sel    = '0;
        in_tag    = '0;

        repeat (2) @(negedge clk);
        check_hs("reset", 1'b0, 1'b0);
        check("reset imm32", 64'(imm32), 64'd0);
        check("reset imm64", imm64, 64'd0);
        check("reset tag32", 64'(tag32), 64'd0);
        check("reset err64", 64'(e64), 64'd0);

        rst_n = 1'b1;
        #1;
        check_hs("release pre-edge", 1'b0, 1'b0);
        @(negedge clk);
        check_hs("release post-edge", 1'b0, 1'b1);

        // Streaming table with out_ready=1: one result per cycle.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].inst, vecs[i].sel, vecs[i].tag);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].exp32, vecs[i].exp64, vecs[i].tag,
                      vecs[i].err);
            check($sformatf("vec%0d rdy32", i), 64'(rdy32), 64'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_hs("stream drained", 1'b0, 1'b1);

        // Stall: three back-to-back beats, only two fit.
        out_ready = 1'b0;
        drive(i_inst(1), 3'b011, 5'd1);
        @(negedge clk);
        check_hs("stall c1", 1'b1, 1'b1);
        check_out("stall c1", 32'd1, 64'd1, 5'd1, 1'b0);
        drive(i_inst(2), 3'b011, 5'd2);
        @(negedge clk);
        check_hs("stall c2", 1'b1, 1'b0);
        check_out("stall c2 hold", 32'd1, 64'd1, 5'd1, 1'b0);
        drive(i_inst(3), 3'b011, 5'd3);
        @(negedge clk);
        check_hs("stall c3", 1'b1, 1'b0);
        check_out("stall c3 hold", 32'd1, 64'd1, 5'd1, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check_hs("drain c4", 1'b1, 1'b1);
        check_out("drain c4", 32'd2, 64'd2, 5'd2, 1'b0);
        @(negedge clk);
        check_out("drain c5", 32'd3, 64'd3, 5'd3, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check_hs("drain c6", 1'b0, 1'b1);

        // Reset with both entries full.
        out_ready = 1'b0;
        drive(i_inst(4), 3'b011, 5'd4);
        @(negedge clk);
        drive(i_inst(5), 3'b011, 5'd5);
        @(negedge clk);
        check_hs("full before reset", 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_hs("async reset", 1'b0, 1'b0);
        check("async reset tag32", 64'(tag32), 64'd0);
        check("async reset imm64", imm64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_hs("post reset empty", 1'b0, 1'b1);
        drive(i_inst(6), 3'b011, 5'd6);
        @(negedge clk);
        check_out("post reset beat", 32'd6, 64'd6, 5'd6, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check_hs("post reset drained", 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
